// File: rtl/bus_scheduler_if.sv
// Shared-memory bus bundle between the slot scheduler and its clients:
// CPU throttle controls, video and DMA request channels, CPU access lines
// and the single-port synchronous RAM port.
interface bus_scheduler_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    // CPU throttle controls
    logic              active;
    logic [7:0]        freq;
    logic [7:0]        fref;

    // Video fetch channel
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic              vid_valid;

    // DMA channel
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_dout;
    logic              dma_gnt;
    logic              dma_valid;

    // CPU access lines and run enable
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_dout;
    logic              hold;

    // RAM port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] mem_din;

    // Scheduler side
    modport slave (
        input  active, freq, fref,
        input  vid_req, vid_addr,
        output vid_gnt, vid_valid,
        input  dma_req, dma_we, dma_addr, dma_dout,
        output dma_gnt, dma_valid,
        input  cpu_we, cpu_addr, cpu_dout,
        output hold,
        output mem_addr, mem_we, mem_dout,
        input  mem_din
    );

    // Client / memory side
    modport master (
        output active, freq, fref,
        output vid_req, vid_addr,
        input  vid_gnt, vid_valid,
        output dma_req, dma_we, dma_addr, dma_dout,
        input  dma_gnt, dma_valid,
        output cpu_we, cpu_addr, cpu_dout,
        input  hold,
        input  mem_addr, mem_we, mem_dout,
        output mem_din
    );
endinterface

// File: rtl/bus_scheduler.sv
// Time-slot scheduler for the shared memory bus. Each clock one owner
// (video, DMA, CPU or nobody) is chosen for the next slot. The CPU only
// becomes eligible when a fractional credit accumulator (freq/fref) has
// produced a credit, so its effective rate tracks the requested frequency.
// Video bursts are capped at VID_MAX consecutive slots when others wait.
module bus_scheduler #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int VID_MAX = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    bus_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_DMA  = 2'd2,
        OWN_CPU  = 2'd3
    } own_e;

    localparam logic [3:0] VID_RUN_MAX = 4'(VID_MAX);

    // Slot owner state
    own_e              own_q;
    own_e              own_d;

    // Throttle state
    logic [8:0]        acc_q;
    logic [8:0]        acc_d;
    logic              cpu_pend_q;
    logic              cpu_pend_d;

    // Video run-length guard
    logic [3:0]        vid_run_q;
    logic [3:0]        vid_run_d;

    // Registered outputs
    logic              vid_gnt_q;
    logic              vid_gnt_d;
    logic              dma_gnt_q;
    logic              dma_gnt_d;
    logic              hold_q;
    logic              hold_d;
    logic              vid_valid_q;
    logic              vid_valid_d;
    logic              dma_valid_q;
    logic              dma_valid_d;

    // Combinational helpers
    logic [8:0]        sum_s;
    logic              tick_s;
    logic              cpu_elig_s;
    logic              vid_cap_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] mem_dout_s;

    // Fractional credit accumulator: produces one CPU credit per fref/freq clocks.
    always_comb begin
        sum_s  = acc_q + {1'b0, bus.freq};
        tick_s = 1'b0;
        acc_d  = acc_q;
        if (!bus.active) begin
            acc_d = 9'd0;
        end else if (bus.freq == 8'd0) begin
            // zero rate never earns a credit
            acc_d = 9'd0;
        end else if ((bus.fref == 8'd0) || (bus.freq >= bus.fref)) begin
            // at or above the reference rate: a credit every clock, nothing carried
            tick_s = 1'b1;
            acc_d  = 9'd0;
        end else if (sum_s >= {1'b0, bus.fref}) begin
            tick_s = 1'b1;
            acc_d  = sum_s - {1'b0, bus.fref};
        end else begin
            acc_d = sum_s;
        end
    end

    // Next-slot owner: video > DMA > CPU > none, with the video burst cap.
    always_comb begin
        cpu_elig_s = bus.active && (cpu_pend_q || tick_s);
        vid_cap_s  = (vid_run_q >= VID_RUN_MAX) && (bus.dma_req || cpu_elig_s);
        own_d      = OWN_NONE;
        if (bus.vid_req && !vid_cap_s) begin
            own_d = OWN_VID;
        end else if (bus.dma_req) begin
            own_d = OWN_DMA;
        end else if (cpu_elig_s) begin
            own_d = OWN_CPU;
        end else begin
            own_d = OWN_NONE;
        end
    end

    // Pending CPU credit and consecutive-video counter for the next slot.
    always_comb begin
        cpu_pend_d = cpu_pend_q;
        vid_run_d  = vid_run_q;
        if (!bus.active) begin
            cpu_pend_d = 1'b0;
        end else if (own_d == OWN_CPU) begin
            // the grant consumes the credit, including one earned this clock
            cpu_pend_d = 1'b0;
        end else if (tick_s) begin
            // a single pending credit; extra credits are dropped
            cpu_pend_d = 1'b1;
        end else begin
            cpu_pend_d = cpu_pend_q;
        end

        if (own_d == OWN_VID) begin
            if (vid_run_q == 4'hF) begin
                vid_run_d = vid_run_q;
            end else begin
                vid_run_d = vid_run_q + 4'd1;
            end
        end else begin
            vid_run_d = 4'd0;
        end
    end

    // Output decode: grants from the next owner, valids from the current slot.
    always_comb begin
        vid_gnt_d   = 1'b0;
        dma_gnt_d   = 1'b0;
        hold_d      = 1'b0;
        case (own_d)
            OWN_VID:  vid_gnt_d = 1'b1;
            OWN_DMA:  dma_gnt_d = 1'b1;
            OWN_CPU:  hold_d    = 1'b1;
            OWN_NONE: hold_d    = 1'b0;
            default:  hold_d    = 1'b0;
        endcase
        vid_valid_d = (own_q == OWN_VID);
        dma_valid_d = (own_q == OWN_DMA) && !bus.dma_we;
    end

    // Slot owner register; the CPU owns the bus while in reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            own_q <= OWN_CPU;
        end else begin
            own_q <= own_d;
        end
    end

    // Throttle, guard counter and registered output flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= 9'd0;
            cpu_pend_q  <= 1'b0;
            vid_run_q   <= 4'd0;
            vid_gnt_q   <= 1'b0;
            dma_gnt_q   <= 1'b0;
            hold_q      <= 1'b1;
            vid_valid_q <= 1'b0;
            dma_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cpu_pend_q  <= cpu_pend_d;
            vid_run_q   <= vid_run_d;
            vid_gnt_q   <= vid_gnt_d;
            dma_gnt_q   <= dma_gnt_d;
            hold_q      <= hold_d;
            vid_valid_q <= vid_valid_d;
            dma_valid_q <= dma_valid_d;
        end
    end

    // RAM port mux from the current slot owner; an idle slot is a quiet read of 0.
    always_comb begin
        mem_addr_s = '0;
        mem_we_s   = 1'b0;
        mem_dout_s = '0;
        case (own_q)
            OWN_VID: begin
                mem_addr_s = bus.vid_addr;
            end
            OWN_DMA: begin
                mem_addr_s = bus.dma_addr;
                mem_we_s   = bus.dma_we;
                mem_dout_s = bus.dma_dout;
            end
            OWN_CPU: begin
                mem_addr_s = bus.cpu_addr;
                mem_we_s   = bus.cpu_we;
                mem_dout_s = bus.cpu_dout;
            end
            OWN_NONE: begin
                mem_addr_s = '0;
            end
            default: begin
                mem_addr_s = '0;
            end
        endcase
    end

    assign bus.vid_gnt   = vid_gnt_q;
    assign bus.dma_gnt   = dma_gnt_q;
    assign bus.hold      = hold_q;
    assign bus.vid_valid = vid_valid_q;
    assign bus.dma_valid = dma_valid_q;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_dout  = mem_dout_s;

endmodule

// File: tb/tb_bus_scheduler.sv
// Directed bench for bus_scheduler: throttle rates, video burst cap, DMA
// read/write timing, active drop and asynchronous reset. A small synchronous
// RAM model answers the memory port.
module tb_bus_scheduler;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    bus_scheduler_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    bus_scheduler #(.ADDR_W(16), .DATA_W(8), .VID_MAX(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Synchronous single-port RAM: read data one clock after address.
    logic [7:0] ram [0:65535];
    always @(posedge clock) begin
        if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_dout;
        end
        bus.mem_din <= ram[bus.mem_addr];
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        int cnt;
        int first_idx;
        logic exp_dma;

        bus.active   = 1'b1;
        bus.freq     = 8'd125;
        bus.fref     = 8'd250;
        bus.vid_req  = 1'b0;
        bus.vid_addr = 16'h0100;
        bus.dma_req  = 1'b0;
        bus.dma_we   = 1'b0;
        bus.dma_addr = 16'h0000;
        bus.dma_dout = 8'h00;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 16'h00C0;
        bus.cpu_dout = 8'h3C;
        ram[16'h0100] = 8'h11;
        ram[16'h1234] = 8'h5A;
        ram[16'h00C0] = 8'h00;

        // reset state
        #1 reset_n = 1'b0;
        #1;
        check_val("rst_hold", 32'(bus.hold), 32'd1);
        check_val("rst_vid_gnt", 32'(bus.vid_gnt), 32'd0);
        check_val("rst_dma_gnt", 32'(bus.dma_gnt), 32'd0);
        check_val("rst_vid_valid", 32'(bus.vid_valid), 32'd0);
        check_val("rst_dma_valid", 32'(bus.dma_valid), 32'd0);
        check_val("rst_mem_addr", 32'(bus.mem_addr), 32'h00C0);

        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        bus.cpu_we = 1'b1;

        // half rate: hold 0,1,0,1 ... and 250 of 500
        cnt = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (bus.hold) cnt++;
            if (i < 8) check_val($sformatf("half_hold_%0d", i), 32'(bus.hold), 32'(i % 2));
            if (i == 0) begin
                check_val("idle_mem_addr", 32'(bus.mem_addr), 32'h0000);
                check_val("idle_mem_we", 32'(bus.mem_we), 32'd0);
            end
            if (i == 1) begin
                check_val("cpu_mem_we", 32'(bus.mem_we), 32'd1);
                check_val("cpu_mem_addr", 32'(bus.mem_addr), 32'h00C0);
                check_val("cpu_mem_dout", 32'(bus.mem_dout), 32'h3C);
            end
            if (i == 3) bus.cpu_we = 1'b0;
        end
        check_val("half_hold_count", 32'(cnt), 32'd250);

        // zero rate never runs the CPU
        bus.freq = 8'd0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (bus.hold) cnt++;
        end
        check_val("zero_hold_count", 32'(cnt), 32'd0);

        // 1/250 rate: two credits in 500 clocks, first at the 250th
        bus.freq = 8'd1;
        cnt = 0;
        first_idx = -1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (bus.hold) begin
                cnt++;
                if (first_idx < 0) first_idx = i;
            end
        end
        check_val("slow_hold_count", 32'(cnt), 32'd2);
        check_val("slow_first_idx", 32'(first_idx), 32'd249);

        // full rate: CPU every clock
        bus.freq = 8'd250;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus.hold) cnt++;
        end
        check_val("full_hold_count", 32'(cnt), 32'd50);

        // video burst of 5 at full rate: ticks collapse, CPU resumes right after
        bus.vid_req = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clock);
            check_val($sformatf("burst_vid_gnt_%0d", j), 32'(bus.vid_gnt), 32'd1);
            check_val($sformatf("burst_hold_%0d", j), 32'(bus.hold), 32'd0);
            check_val($sformatf("burst_vid_valid_%0d", j), 32'(bus.vid_valid), 32'(j > 0));
            check_val($sformatf("burst_mem_addr_%0d", j), 32'(bus.mem_addr), 32'h0100);
            if (j > 0) check_val($sformatf("burst_mem_din_%0d", j), 32'(bus.mem_din), 32'h11);
        end
        bus.vid_req = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            check_val($sformatf("post_hold_%0d", j), 32'(bus.hold), 32'd1);
            check_val($sformatf("post_vid_valid_%0d", j), 32'(bus.vid_valid), 32'(j == 0));
        end

        // starvation guard: 8 video slots then one DMA read, repeating
        bus.freq    = 8'd0;
        bus.vid_req = 1'b1;
        bus.dma_req = 1'b1;
        bus.dma_we  = 1'b0;
        bus.dma_addr = 16'h1234;
        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            exp_dma = ((i % 9) == 8);
            check_val($sformatf("starve_dma_gnt_%0d", i), 32'(bus.dma_gnt), 32'(exp_dma));
            check_val($sformatf("starve_vid_gnt_%0d", i), 32'(bus.vid_gnt), 32'(!exp_dma));
            check_val($sformatf("starve_vid_valid_%0d", i), 32'(bus.vid_valid),
                      32'((i > 0) && ((i % 9) != 0)));
            check_val($sformatf("starve_dma_valid_%0d", i), 32'(bus.dma_valid),
                      32'((i > 0) && ((i % 9) == 0)));
        end
        bus.vid_req = 1'b0;
        bus.dma_req = 1'b0;
        @(negedge clock);

        // DMA read of preloaded 0x5A at 0x1234
        bus.dma_req  = 1'b1;
        bus.dma_we   = 1'b0;
        bus.dma_addr = 16'h1234;
        @(negedge clock);
        check_val("dmar_gnt", 32'(bus.dma_gnt), 32'd1);
        check_val("dmar_mem_addr", 32'(bus.mem_addr), 32'h1234);
        check_val("dmar_mem_we", 32'(bus.mem_we), 32'd0);
        bus.dma_req = 1'b0;
        @(negedge clock);
        check_val("dmar_valid", 32'(bus.dma_valid), 32'd1);
        check_val("dmar_data", 32'(bus.mem_din), 32'h5A);
        check_val("dmar_gnt_drop", 32'(bus.dma_gnt), 32'd0);

        // DMA write: RAM write, no valid afterwards
        bus.dma_req  = 1'b1;
        bus.dma_we   = 1'b1;
        bus.dma_addr = 16'h2000;
        bus.dma_dout = 8'hA7;
        @(negedge clock);
        check_val("dmaw_gnt", 32'(bus.dma_gnt), 32'd1);
        check_val("dmaw_mem_we", 32'(bus.mem_we), 32'd1);
        check_val("dmaw_mem_addr", 32'(bus.mem_addr), 32'h2000);
        check_val("dmaw_mem_dout", 32'(bus.mem_dout), 32'hA7);
        bus.dma_req = 1'b0;
        @(negedge clock);
        check_val("dmaw_valid", 32'(bus.dma_valid), 32'd0);
        check_val("dmaw_ram", 32'(ram[16'h2000]), 32'hA7);
        bus.dma_we = 1'b0;

        // active drop clears the accumulator mid-period
        bus.freq = 8'd125;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_val($sformatf("act_pre_hold_%0d", i), 32'(bus.hold), 32'(i == 1));
        end
        bus.active = 1'b0;
        bus.freq   = 8'd250;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (bus.hold) cnt++;
        end
        check_val("inactive_hold_count", 32'(cnt), 32'd0);
        bus.freq   = 8'd125;
        bus.active = 1'b1;
        @(negedge clock);
        check_val("act_resume_hold_0", 32'(bus.hold), 32'd0);
        @(negedge clock);
        check_val("act_resume_hold_1", 32'(bus.hold), 32'd1);

        // reset pulse in the middle of a DMA read slot
        bus.dma_req  = 1'b1;
        bus.dma_addr = 16'h1234;
        @(negedge clock);
        check_val("rstdma_gnt", 32'(bus.dma_gnt), 32'd1);
        bus.dma_req = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_val("rstdma_hold", 32'(bus.hold), 32'd1);
        check_val("rstdma_dma_gnt", 32'(bus.dma_gnt), 32'd0);
        @(negedge clock);
        check_val("rstdma_dma_valid", 32'(bus.dma_valid), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check_val("rstdma_after_hold", 32'(bus.hold), 32'd0);
        @(negedge clock);
        check_val("rstdma_after_hold_1", 32'(bus.hold), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/bus_scheduler.md
# bus_scheduler

Time-slot scheduler for the shared memory bus: arbitrates each clock between video fetch, DMA and the CPU, and drives the CPU `hold` run-enable so the CPU executes only in granted slots. The CPU is additionally throttled to a requested effective frequency by a fractional credit accumulator. The block sits between the CPU core, the video and DMA engines, and the single-port synchronous RAM.

## Interface
- `ADDR_W`, 16, memory address width
- `DATA_W`, 8, memory data width
- `VID_MAX`, 8, max consecutive video slots before one slot is forced to DMA/CPU if either is waiting
- `clock`  in  1  system clock; all registers on posedge
- `reset_n`  in  1  asynchronous, active-low reset
- `active`  in  1  1 = CPU throttle enabled; 0 = CPU stopped
- `freq`  in  8  requested CPU rate, units of 0.1 MHz (12.5 MHz = 125)
- `fref`  in  8  clock rate, same units (25 MHz = 250)
- `vid_req`  in  1  video wants a slot (level)
- `vid_addr`  in  ADDR_W  video read address
- `vid_gnt`  out  1  video owns the current slot
- `vid_valid`  out  1  `mem_din` holds video read data
- `dma_req`  in  1  DMA wants a slot (level, held until `dma_gnt`)
- `dma_we`  in  1  DMA write strobe
- `dma_addr`  in  ADDR_W  DMA address
- `dma_dout`  in  DATA_W  DMA write data
- `dma_gnt`  out  1  DMA owns the current slot
- `dma_valid`  out  1  `mem_din` holds DMA read data
- `cpu_we`  in  1  CPU write strobe
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_dout`  in  DATA_W  CPU write data
- `hold`  out  1  1 = CPU runs this cycle (owns bus), 0 = CPU held
- `mem_addr`  out  ADDR_W  RAM address
- `mem_we`  out  1  RAM write enable
- `mem_dout`  out  DATA_W  RAM write data
- `mem_din`  in  DATA_W  RAM read data, valid one cycle after address

## Operation
- Slot owner register `own` ∈ {NONE, VID, DMA, CPU}; `vid_gnt`, `dma_gnt`, `hold` are its registered one-hot decode.
- `mem_addr`/`mem_we`/`mem_dout` combinationally muxed from `own` and the owner's inputs; NONE drives `mem_we`=0, `mem_addr`=0.
- Throttle: 9-bit accumulator `acc`. Each cycle with `active`=1: `s = acc + freq`; if `s >= fref` then `acc <= s - fref`, credit tick, else `acc <= s`. Width: `s` computed in 9 bits, no overflow since `acc < fref <= 255`.
- `freq >= fref` or `fref`=0: tick every cycle. `freq`=0: never ticks.
- Tick sets `cpu_pend`; pending saturates at 1 (excess credits dropped). `cpu_pend` cleared when CPU slot granted.
- `active`=0: `acc`, `cpu_pend` cleared; CPU never granted; video/DMA unaffected.
- Next-owner priority: VID (if `vid_req`) > DMA (if `dma_req`) > CPU (if `cpu_pend` or tick this cycle) > NONE.
- Starvation guard: 4-bit `vid_run` counts consecutive VID slots; when `vid_run == VID_MAX` and (`dma_req` or CPU eligible), next slot goes to DMA/CPU by normal order; `vid_run` resets on any non-VID slot.
- `vid_valid`/`dma_valid`: registered, asserted the cycle after a VID slot / DMA read slot (no valid after DMA write).

## Timing
- Reset (async assert): `own`=CPU so `hold`=1 (CPU runs through its own reset), `vid_gnt`=`dma_gnt`=0, valids 0, `acc`=0, `cpu_pend`=0, `vid_run`=0. First posedge after release resumes normal scheduling.
- Grant latency: request sampled at edge N, grant visible cycle N+1; DMA must hold `dma_req` until it sees `dma_gnt`, and drop it that cycle for a single access.
- Read latency: data in `mem_din` during cycle after slot, flagged by valid.
- Simultaneous tick and VID/DMA slot: tick goes to `cpu_pend`, CPU runs first free slot.
- Steady CPU-only, `freq`=125, `fref`=250: `hold` toggles 1,0,1,0.
- Reset asserted mid-slot: outputs take reset values immediately; in-flight valid is lost.

## Test plan
- Reset, `active`=1, `freq`=125, `fref`=250, no other requests -> `hold` pattern 1,0,1,0 after first tick; 500 cycles give exactly 250 `hold` cycles.
- `freq`=1, `fref`=250 -> one `hold` cycle per 250 clocks; `freq`=0 -> `hold` stays 0; `freq`=250 -> `hold` always 1.
- `vid_req` held high, `dma_req` high, `VID_MAX`=8 -> 8 VID slots, 1 DMA slot, repeat; `vid_valid` follows each VID slot by 1 cycle.
- DMA read addr 0x1234 with RAM preloaded 0x5A -> `dma_gnt` next cycle, `mem_addr`=0x1234, `dma_valid`=1 with `mem_din`=0x5A one cycle later; DMA write -> `mem_we`=1, no `dma_valid`.
- `freq`=250, `fref`=250 with video burst of 5 -> 5 ticks collapse to one pending; single `hold`=1 right after burst, then every cycle.
- `active`=0 mid-run -> `hold`=0 next cycle, `acc` cleared; `reset_n` pulse during DMA slot -> `hold`=1, `dma_gnt`=0 immediately.
